sample_writer: RTL and testbench
================================

SAMPLE_WRITER -- requirements
Module: sample_writer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the sample and RAM data width in bits.
REQ-002 The module SHALL have parameter ADDR, default 8, giving the RAM address width (depth 2**ADDR).
REQ-003 The module SHALL have parameter DECIM, default 4, giving the accepted samples per RAM write (DECIM >= 1).
REQ-004 The module SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 The module SHALL have port i_rst  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port i_sample  input  WIDTH  signed two's-complement audio sample.
REQ-007 The module SHALL have port i_valid  input  1  i_sample valid this cycle.
REQ-008 The module SHALL have port o_ready  output  1  sample accepted when i_valid && o_ready.
REQ-009 The module SHALL have port i_clear  input  1  synchronous clear of pointer, flags and accumulator.
REQ-010 The module SHALL have port o_addr  output  ADDR  RAM address.
REQ-011 The module SHALL have port o_rw  output  1  RAM direction (0 = read, 1 = write).
REQ-012 The module SHALL have port o_wen  output  1  RAM write enable.
REQ-013 The module SHALL have port o_data  output  WIDTH  RAM write data (unsigned magnitude).
REQ-014 The module SHALL have port o_wptr  output  ADDR  next write address.
REQ-015 The module SHALL have port o_full  output  1  buffer written completely at least once.
REQ-016 The module SHALL have port o_peak  output  WIDTH  peak-hold value (see Configuration).

Function
REQ-017 Magnitude SHALL be |i_sample|; the most negative value SHALL saturate to 2**(WIDTH-1)-1.
REQ-018 The FSM SHALL have states ACC (o_ready=1) and WRITE (o_ready=0, exactly one cycle).
REQ-019 In ACC, each accepted sample SHALL update the accumulator to max(accumulator, magnitude) and increment the sample counter.
REQ-020 The DECIM-th accepted sample SHALL move the FSM to WRITE on the next edge, folding its own magnitude into the written value.
REQ-021 In WRITE, o_rw=1, o_wen=1, o_addr=o_wptr and o_data=block maximum SHALL hold; latency is one cycle after the DECIM-th accept.
REQ-022 On leaving WRITE, o_wptr SHALL increment, the accumulator and counter SHALL clear, and the FSM SHALL return to ACC.
REQ-023 Outside WRITE, o_rw=0, o_wen=0 and o_data=0 SHALL hold, and o_addr SHALL equal o_wptr.
REQ-024 o_wptr SHALL wrap from 2**ADDR-1 to 0; that wrap SHALL set o_full, which stays set until clear or reset.
REQ-025 i_clear SHALL override i_valid in the same cycle: the sample is dropped; o_wptr, counter, accumulator and o_full go to 0; FSM goes to ACC.
REQ-026 i_clear during WRITE SHALL still complete that cycle's RAM write, then apply the clear.

Reset
REQ-027 While i_rst=0, all state SHALL be cleared immediately: FSM=ACC, o_wptr=0, o_full=0, o_peak=0, accumulator=0, counter=0.
REQ-028 While i_rst=0, o_rw=0, o_wen=0, o_data=0 and o_addr=0 SHALL hold, and o_ready SHALL be 0.
REQ-029 Reset asserted during WRITE SHALL abort the write, leaving no partial wen pulse after assertion.

Configuration
REQ-030 Macro SAMPLE_WRITER_PEAK_HOLD_EN defined: o_peak SHALL equal the maximum of all values written since reset/clear, updated on the cycle after WRITE.
REQ-031 Macro SAMPLE_WRITER_PEAK_HOLD_EN undefined: o_peak SHALL be constant 0 and no peak register SHALL exist.

Structure
REQ-032 A shared package sample_writer_pkg SHALL hold the FSM state encoding (ACC=0, WRITE=1) and the default parameter constants.
REQ-033 The magnitude/saturation logic SHALL be a sub-module named abs_sat (combinational, parameter WIDTH).

Verification (WIDTH=8, ADDR=4, DECIM=4)
REQ-034 Release reset -> o_ready=1, o_wptr=0, o_full=0, o_wen=0, o_peak=0.
REQ-035 Accept samples 3, -7, 5, 2 on consecutive cycles -> one cycle with o_wen=1, o_addr=0, o_data=7; then o_wptr=1.
REQ-036 Block of -128, 0, 0, 0 -> o_data=127; i_valid held during WRITE -> that sample is not accepted.
REQ-037 Write 16 blocks -> o_wptr returns to 0 and o_full=1; i_clear then -> o_wptr=0, o_full=0.
REQ-038 i_clear after 2 accepted samples, then 4 samples of value 1 -> written o_data=1 at addr 0.
REQ-039 With macro, blocks of max 7 then 3 -> o_peak=7; without macro -> o_peak=0; reset asserted in WRITE -> o_wen drops immediately.

Source files
------------

// File: rtl/sample_writer_pkg.sv
// Shared constants and FSM encoding for the decimating peak sample writer.
package sample_writer_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultAddr  = 8;
  localparam int unsigned DefaultDecim = 4;

  typedef enum logic [0:0] {
    StAcc   = 1'b0,
    StWrite = 1'b1
  } state_e;

endpackage

// File: rtl/abs_sat.sv
// Combinational magnitude of a signed sample; the most negative code saturates to max positive.
module abs_sat #(
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] sample_i,
  output logic        [WIDTH-1:0] mag_o
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] neg;

  assign raw = sample_i;
  assign neg = ~raw + 1'b1;

  always_comb begin
    mag_o = raw;
    if (raw[WIDTH-1]) begin
      // Only 100..0 has no positive counterpart.
      if (raw[WIDTH-2:0] == '0) begin
        mag_o = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        mag_o = neg;
      end
    end
  end

endmodule

// File: rtl/sample_writer.sv
// Decimating sample writer: stores the peak magnitude of every DECIM accepted samples into a RAM.
// Optional peak-hold output is enabled by defining SAMPLE_WRITER_PEAK_HOLD_EN.
module sample_writer
  import sample_writer_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ADDR  = DefaultAddr,
  parameter int unsigned DECIM = DefaultDecim
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic signed [WIDTH-1:0] i_sample,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_clear,
  output logic        [ADDR-1:0]  o_addr,
  output logic                    o_rw,
  output logic                    o_wen,
  output logic        [WIDTH-1:0] o_data,
  output logic        [ADDR-1:0]  o_wptr,
  output logic                    o_full,
  output logic        [WIDTH-1:0] o_peak
);

  localparam int unsigned CntW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DECIM - 1);

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] data_q;
  logic [ADDR-1:0]  wptr_q;
  logic             full_q;
  logic             ready_q;

  logic [WIDTH-1:0] mag;
  logic [WIDTH-1:0] blk_max;
  logic             accept;
  logic             writing;

  abs_sat #(
    .WIDTH(WIDTH)
  ) u_abs_sat (
    .sample_i(i_sample),
    .mag_o   (mag)
  );

  assign blk_max = (mag > acc_q) ? mag : acc_q;
  assign accept  = i_valid && ready_q;
  assign writing = (state_q == StWrite);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StAcc;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      wptr_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b0;
    end else if (i_clear) begin
      // A write in progress is still driven this cycle; clear lands at the edge.
      state_q <= StAcc;
      cnt_q   <= '0;
      acc_q   <= '0;
      wptr_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StAcc: begin
          ready_q <= 1'b1;
          if (accept) begin
            acc_q <= blk_max;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              data_q  <= blk_max;
              state_q <= StWrite;
              ready_q <= 1'b0;
            end
          end
        end
        StWrite: begin
          wptr_q  <= wptr_q + 1'b1;
          if (wptr_q == '1) begin
            full_q <= 1'b1;
          end
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= StAcc;
          ready_q <= 1'b1;
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_rw    = writing;
  assign o_wen   = writing;
  assign o_addr  = wptr_q;
  assign o_data  = writing ? data_q : '0;
  assign o_wptr  = wptr_q;
  assign o_full  = full_q;

`ifdef SAMPLE_WRITER_PEAK_HOLD_EN
  logic [WIDTH-1:0] peak_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      peak_q <= '0;
    end else if (i_clear) begin
      peak_q <= '0;
    end else if (writing && (data_q > peak_q)) begin
      peak_q <= data_q;
    end
  end

  assign o_peak = peak_q;
`else
  assign o_peak = '0;
`endif

endmodule

// File: tb/tb_sample_writer.sv
// Directed bench for sample_writer (WIDTH=8, ADDR=4, DECIM=4); follows SAMPLE_WRITER_PEAK_HOLD_EN.
module tb_sample_writer;

  logic              i_clk;
  logic              i_rst;
  logic signed [7:0] i_sample;
  logic              i_valid;
  logic              o_ready;
  logic              i_clear;
  logic [3:0]        o_addr;
  logic              o_rw;
  logic              o_wen;
  logic [7:0]        o_data;
  logic [3:0]        o_wptr;
  logic              o_full;
  logic [7:0]        o_peak;

  int checks;
  int failures;

`ifdef SAMPLE_WRITER_PEAK_HOLD_EN
  localparam logic [7:0] PeakExp = 8'd7;
`else
  localparam logic [7:0] PeakExp = 8'd0;
`endif

  sample_writer #(
    .WIDTH(8),
    .ADDR (4),
    .DECIM(4)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_sample(i_sample),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_clear (i_clear),
    .o_addr  (o_addr),
    .o_rw    (o_rw),
    .o_wen   (o_wen),
    .o_data  (o_data),
    .o_wptr  (o_wptr),
    .o_full  (o_full),
    .o_peak  (o_peak)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic signed [7:0] s);
    i_valid  = 1'b1;
    i_sample = s;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_sample = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_sample = '0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%0b exp=0", o_ready); end
    checks++; if (o_wen !== 1'b0 || o_rw !== 1'b0) begin failures++; $display("FAIL rst_wen got=%0b/%0b exp=0/0", o_wen, o_rw); end
    checks++; if (o_addr !== 4'd0 || o_data !== 8'd0) begin failures++; $display("FAIL rst_addr_data got=%0d/%0d exp=0/0", o_addr, o_data); end
    @(negedge i_clk);
    i_rst = 1'b1;
    step();
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rel_ready got=%0b exp=1", o_ready); end
    checks++; if (o_wptr !== 4'd0 || o_full !== 1'b0) begin failures++; $display("FAIL rel_wptr_full got=%0d/%0b exp=0/0", o_wptr, o_full); end
    checks++; if (o_wen !== 1'b0 || o_peak !== 8'd0) begin failures++; $display("FAIL rel_wen_peak got=%0b/%0d exp=0/0", o_wen, o_peak); end
  endtask

  task automatic test_basic();
    push(8'sd3); push(-8'sd7); push(8'sd5); push(8'sd2);
    checks++; if (o_wen !== 1'b1 || o_rw !== 1'b1) begin failures++; $display("FAIL basic_wen got=%0b/%0b exp=1/1", o_wen, o_rw); end
    checks++; if (o_addr !== 4'd0) begin failures++; $display("FAIL basic_addr got=%0d exp=0", o_addr); end
    checks++; if (o_data !== 8'd7) begin failures++; $display("FAIL basic_data got=%0d exp=7", o_data); end
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL basic_ready got=%0b exp=0", o_ready); end
    step();
    checks++; if (o_wptr !== 4'd1 || o_addr !== 4'd1) begin failures++; $display("FAIL basic_wptr got=%0d/%0d exp=1/1", o_wptr, o_addr); end
    checks++; if (o_wen !== 1'b0 || o_data !== 8'd0) begin failures++; $display("FAIL basic_idle got=%0b/%0d exp=0/0", o_wen, o_data); end
  endtask

  task automatic test_sat_stall();
    push(-8'sd128); push(8'sd0); push(8'sd0); push(8'sd0);
    checks++; if (o_data !== 8'd127 || o_addr !== 4'd1) begin failures++; $display("FAIL sat_data got=%0d@%0d exp=127@1", o_data, o_addr); end
    // Held valid during WRITE must not be taken; otherwise the next block writes early with 100.
    i_valid = 1'b1; i_sample = 8'sd100;
    step();
    i_valid = 1'b0; i_sample = '0;
    checks++; if (o_wptr !== 4'd2) begin failures++; $display("FAIL sat_wptr got=%0d exp=2", o_wptr); end
    push(8'sd1); push(8'sd1); push(8'sd1);
    checks++; if (o_wen !== 1'b0) begin failures++; $display("FAIL stall_early_wen got=%0b exp=0", o_wen); end
    push(8'sd1);
    checks++; if (o_wen !== 1'b1 || o_data !== 8'd1 || o_addr !== 4'd2) begin
      failures++; $display("FAIL stall_write got=%0b/%0d@%0d exp=1/1@2", o_wen, o_data, o_addr); end
    step();
  endtask

  task automatic test_wrap_clear();
    for (int b = 0; b < 13; b++) begin
      repeat (4) push(8'sd2);
      step();
      if (b == 11) begin
        checks++; if (o_wptr !== 4'd15 || o_full !== 1'b0) begin
          failures++; $display("FAIL wrap_pre got=%0d/%0b exp=15/0", o_wptr, o_full); end
      end
    end
    checks++; if (o_wptr !== 4'd0 || o_full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%0d/%0b exp=0/1", o_wptr, o_full); end
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    checks++; if (o_wptr !== 4'd0 || o_full !== 1'b0) begin failures++; $display("FAIL wrap_clear got=%0d/%0b exp=0/0", o_wptr, o_full); end
    checks++; if (o_peak !== 8'd0) begin failures++; $display("FAIL clear_peak got=%0d exp=0", o_peak); end
  endtask

  task automatic test_clear_mid_block();
    push(8'sd9); push(8'sd9);
    i_clear = 1'b1; i_valid = 1'b1; i_sample = 8'sd50;
    step();
    i_clear = 1'b0; i_valid = 1'b0; i_sample = '0;
    push(8'sd1); push(8'sd1); push(8'sd1);
    checks++; if (o_wen !== 1'b0) begin failures++; $display("FAIL clrmid_early_wen got=%0b exp=0", o_wen); end
    push(8'sd1);
    checks++; if (o_wen !== 1'b1 || o_data !== 8'd1 || o_addr !== 4'd0) begin
      failures++; $display("FAIL clrmid_write got=%0b/%0d@%0d exp=1/1@0", o_wen, o_data, o_addr); end
    step();
  endtask

  task automatic test_clear_in_write();
    repeat (4) push(8'sd6);
    i_clear = 1'b1;
    #1;
    checks++; if (o_wen !== 1'b1 || o_data !== 8'd6 || o_addr !== 4'd1) begin
      failures++; $display("FAIL clrwr_write got=%0b/%0d@%0d exp=1/6@1", o_wen, o_data, o_addr); end
    step();
    i_clear = 1'b0;
    checks++; if (o_wptr !== 4'd0 || o_ready !== 1'b1 || o_wen !== 1'b0) begin
      failures++; $display("FAIL clrwr_after got=%0d/%0b/%0b exp=0/1/0", o_wptr, o_ready, o_wen); end
  endtask

  task automatic test_peak();
    push(8'sd7); push(8'sd1); push(8'sd1); push(8'sd1);
    checks++; if (o_peak !== 8'd0) begin failures++; $display("FAIL peak_during got=%0d exp=0", o_peak); end
    step();
    checks++; if (o_peak !== PeakExp) begin failures++; $display("FAIL peak_first got=%0d exp=%0d", o_peak, PeakExp); end
    repeat (4) push(-8'sd3);
    checks++; if (o_data !== 8'd3) begin failures++; $display("FAIL peak_blk2 got=%0d exp=3", o_data); end
    step();
    checks++; if (o_peak !== PeakExp) begin failures++; $display("FAIL peak_hold got=%0d exp=%0d", o_peak, PeakExp); end
  endtask

  task automatic test_reset_in_write();
    repeat (4) push(8'sd5);
    checks++; if (o_wen !== 1'b1) begin failures++; $display("FAIL rstwr_pre got=%0b exp=1", o_wen); end
    #2;
    i_rst = 1'b0;
    #1;
    checks++; if (o_wen !== 1'b0 || o_rw !== 1'b0) begin failures++; $display("FAIL rstwr_wen got=%0b/%0b exp=0/0", o_wen, o_rw); end
    checks++; if (o_data !== 8'd0 || o_addr !== 4'd0 || o_ready !== 1'b0) begin
      failures++; $display("FAIL rstwr_outs got=%0d/%0d/%0b exp=0/0/0", o_data, o_addr, o_ready); end
    checks++; if (o_wptr !== 4'd0 || o_peak !== 8'd0) begin failures++; $display("FAIL rstwr_state got=%0d/%0d exp=0/0", o_wptr, o_peak); end
    @(negedge i_clk);
    i_rst = 1'b1;
    step();
    checks++; if (o_ready !== 1'b1 || o_wen !== 1'b0) begin failures++; $display("FAIL rstwr_rel got=%0b/%0b exp=1/0", o_ready, o_wen); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_sat_stall();
    test_wrap_clear();
    test_clear_mid_block();
    test_clear_in_write();
    test_peak();
    test_reset_in_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
